// File: rtl/tgate_bus_pkg.sv
// Shared types and sizing helpers for the transmission-gate bus driver.
package tgate_bus_pkg;

  // Controller phases. IDLE accepts, SETUP waits for grant with gates off,
  // DRIVE passes data onto the net, TURN keeps the gates off before the next accept.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    DRIVE = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int DEFAULT_HOLD_CYCLES = 2;
  localparam int DEFAULT_TURN_CYCLES = 1;

  // Width of the phase counter. It must hold the larger of the two reload
  // values. Both values are at least 1, so the result is always at least 1 bit.
  function automatic int cnt_width(input int hold_cycles, input int turn_cycles);
    int longest;
    longest = (hold_cycles > turn_cycles) ? hold_cycles : turn_cycles;
    return $clog2(longest + 1);
  endfunction

endpackage

// File: rtl/tgate_bus_driver.sv
// Transmit-side controller for a shared transmission-gate bus.
// It accepts one word over valid/ready, holds that word on bus_data, and
// sequences bus_en as follows: a setup cycle with the gates off, a drive window
// of HOLD_CYCLES cycles while grant is held, then a turnaround gap of
// TURN_CYCLES cycles. This keeps two drivers from overlapping on the shared net.
// Every output comes from a register.
module tgate_bus_driver
  import tgate_bus_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES,
  parameter int TURN_CYCLES = DEFAULT_TURN_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  input  logic [WIDTH-1:0] s_data,
  output logic             s_ready,
  input  logic             bus_grant,
  output logic [WIDTH-1:0] bus_data,
  output logic             bus_en,
  output logic             busy,
  output logic             done,
  output logic             abort
);

  localparam int CW = cnt_width(HOLD_CYCLES, TURN_CYCLES);

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] TURN_LOAD = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0] data_n;
  logic            en_n;
  logic            ready_n;
  logic            busy_n;
  logic            done_n;
  logic            abort_n;

  // Next-state and next-output decode. Every decision is evaluated for the coming edge.
  always_comb begin
    // NOTE: every signal assigned here gets a default first. A path that
    // misses an assignment would otherwise infer a latch.
    state_n = state;
    cnt_n   = cnt;
    data_n  = bus_data;
    en_n    = 1'b0;
    done_n  = 1'b0;
    abort_n = 1'b0;

    unique case (state)
      IDLE: begin
        // s_ready is registered, so it is still low on the first cycle after reset.
        if (s_valid && s_ready) begin
          data_n  = s_data;
          state_n = SETUP;
        end
      end

      SETUP: begin
        // Gates stay off for at least this one cycle. The wait for grant has no timeout.
        if (bus_grant) begin
          state_n = DRIVE;
          cnt_n   = HOLD_LOAD;
          en_n    = 1'b1;
        end
      end

      DRIVE: begin
        if (!bus_grant) begin
          // Grant was lost: release the net at once. The word is not retried.
          state_n = TURN;
          cnt_n   = TURN_LOAD;
          abort_n = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_n = TURN;
          cnt_n   = TURN_LOAD;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - CNT_LAST;
          en_n  = 1'b1;
        end
      end

      TURN: begin
        if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - CNT_LAST;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    ready_n = (state_n == IDLE);
    busy_n  = (state_n != IDLE);
  end

  // State, counter and output registers, with synchronous reset that releases the bus.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from the values that were present before the edge.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bus_data <= '0;
      bus_en   <= 1'b0;
      s_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bus_data <= data_n;
      bus_en   <= en_n;
      s_ready  <= ready_n;
      busy     <= busy_n;
      done     <= done_n;
      abort    <= abort_n;
    end
  end

endmodule

// File: tb/tb_tgate_bus_driver.sv
// Bench for tgate_bus_driver. It applies directed scenarios first and then a
// randomized stretch. A behavioural model tracks the expected outputs cycle by cycle.
module tb_tgate_bus_driver;

  localparam int WIDTH = 8;
  localparam int HOLD  = 2;
  localparam int TURN  = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic [WIDTH-1:0] s_data;
  logic             s_ready;
  logic             bus_grant;
  logic [WIDTH-1:0] bus_data;
  logic             bus_en;
  logic             busy;
  logic             done;
  logic             abort;

  // Shared net as the transmission gates present it: high-Z whenever the gates are off.
  wire [WIDTH-1:0] bus_net = bus_en ? bus_data : {WIDTH{1'bz}};

  tgate_bus_driver #(
    .WIDTH(WIDTH),
    .HOLD_CYCLES(HOLD),
    .TURN_CYCLES(TURN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .bus_grant(bus_grant),
    .bus_data(bus_data),
    .bus_en(bus_en),
    .busy(busy),
    .done(done),
    .abort(abort)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state. It records what the word is doing, not how the RTL encodes it.
  bit             m_ready, m_busy, m_en, m_done, m_abort;
  bit             m_waiting;
  int             m_driven, m_gap;
  logic [WIDTH-1:0] m_data;

  int accepts[$];
  int en_high_cnt, done_cnt, abort_cnt;
  bit prev_en;
  logic [WIDTH-1:0] prev_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_ready = 0; m_busy = 0; m_en = 0; m_done = 0; m_abort = 0;
      m_waiting = 0; m_data = '0;
    end else begin
      m_done  = 0;
      m_abort = 0;
      if (m_ready) begin
        if (s_valid) begin
          m_data = s_data; m_ready = 0; m_busy = 1; m_waiting = 1;
        end
      end else if (m_waiting) begin
        if (bus_grant) begin
          m_waiting = 0; m_en = 1; m_driven = 0;
        end
      end else if (m_en) begin
        if (!bus_grant) begin
          m_en = 0; m_abort = 1; m_gap = 0;
        end else begin
          m_driven++;
          if (m_driven == HOLD) begin
            m_en = 0; m_done = 1; m_gap = 0;
          end
        end
      end else if (m_busy) begin
        m_gap++;
        if (m_gap == TURN) begin
          m_busy = 0; m_ready = 1;
        end
      end else begin
        m_ready = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("s_ready", s_ready, m_ready);
    check("busy", busy, m_busy);
    check("bus_en", bus_en, m_en);
    check("done", done, m_done);
    check("abort", abort, m_abort);
    check("bus_data", bus_data, m_data);
    check("done_and_abort", done & abort, 1'b0);
    if (m_en) check("bus_net_driven", bus_net, m_data);
    else      check("bus_net_hiz", bus_net, {WIDTH{1'bz}});
    if (prev_en && bus_en) check("data_stable_in_drive", bus_data, prev_data);
    prev_en   = bus_en;
    prev_data = bus_data;
    if (bus_en) en_high_cnt++;
    if (done)   done_cnt++;
    if (abort)  abort_cnt++;
  endtask

  // Applies one cycle of inputs, advances the model across the edge, then checks outputs on the falling edge.
  task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d, input logic g);
    bit acc;
    rst = r; s_valid = v; s_data = d; bus_grant = g;
    acc = !r && v && m_ready;
    @(posedge clk);
    model_edge();
    cyc++;
    if (acc) accepts.push_back(cyc);
    @(negedge clk);
    compare_all();
  endtask

  task automatic clear_counts();
    en_high_cnt = 0; done_cnt = 0; abort_cnt = 0;
    accepts.delete();
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; bus_grant = 1'b0;
    m_data = '0; prev_en = 0; prev_data = '0;
    @(negedge clk);

    // Reset for two cycles, then send a single word with grant already high.
    step(1, 0, 8'h00, 0);
    step(1, 0, 8'h00, 0);
    check("reset_ready_low", s_ready, 1'b0);
    step(0, 0, 8'h00, 1);
    check("ready_after_reset", s_ready, 1'b1);
    clear_counts();
    step(0, 1, 8'hA5, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1);
    check("single_en_cycles", en_high_cnt, HOLD);
    check("single_done_pulses", done_cnt, 1);
    check("single_data", bus_data, 8'hA5);

    // Accept a word, then hold grant low for four cycles before raising it.
    clear_counts();
    step(0, 1, 8'h3C, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0);
    check("delayed_en_low", en_high_cnt, 0);
    check("delayed_busy", busy, 1'b1);
    for (int i = 0; i < 6; i++) step(0, 0, 8'h00, 1);
    check("delayed_en_cycles", en_high_cnt, HOLD);
    check("delayed_done", done_cnt, 1);

    // Drop grant after the first drive cycle.
    clear_counts();
    step(0, 1, 8'hF0, 1);
    step(0, 0, 8'h00, 1);
    step(0, 0, 8'h00, 0);
    check("lost_en_off", bus_en, 1'b0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 0);
    check("lost_abort", abort_cnt, 1);
    check("lost_no_done", done_cnt, 0);
    check("lost_back_idle", s_ready, 1'b1);

    // Back-to-back words with s_valid held high.
    clear_counts();
    for (int i = 0; i < 16; i++)
      step(0, accepts.size() < 3, 8'(accepts.size() + 1), 1);
    check("b2b_accepts", accepts.size(), 3);
    if (accepts.size() == 3) begin
      check("b2b_gap1", accepts[1] - accepts[0], 2 + HOLD + TURN);
      check("b2b_gap2", accepts[2] - accepts[1], 2 + HOLD + TURN);
    end
    check("b2b_done", done_cnt, 3);
    check("b2b_last_data", bus_data, 8'h03);

    // Assert reset in the middle of a drive window.
    clear_counts();
    step(0, 1, 8'h77, 1);
    step(0, 0, 8'h00, 1);
    check("rst_mid_en_before", bus_en, 1'b1);
    step(1, 0, 8'h00, 1);
    check("rst_mid_en", bus_en, 1'b0);
    check("rst_mid_data", bus_data, 8'h00);
    step(0, 0, 8'h00, 1);
    check("rst_mid_ready", s_ready, 1'b1);
    check("rst_mid_no_pulse", done_cnt + abort_cnt, 0);

    // Change s_data during SETUP and DRIVE; bus_data must keep the latched word.
    step(0, 1, 8'h55, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 8'($urandom), 0);
    for (int i = 0; i < 2; i++) step(0, 1, 8'($urandom), 1);
    check("ignored_data", bus_data, 8'h55);
    for (int i = 0; i < 3; i++) step(0, 0, 8'($urandom), 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(63) == 0), $urandom_range(1), 8'($urandom), ($urandom_range(3) != 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
